// File: rtl/serial_comparator.sv
// Serial magnitude comparator: compares two unsigned words one chunk per cycle,
// most-significant chunk first, and stops at the first chunk that differs.
module serial_comparator #(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned CHUNK_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  ready_o,
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  output logic                  valid_o,
  output logic                  above_o,
  output logic                  below_o,
  output logic                  equal_o
);

  localparam int unsigned N    = WORD_WIDTH / CHUNK_WIDTH;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [WORD_WIDTH-1:0] a_q, a_d;
  logic [WORD_WIDTH-1:0] b_q, b_d;
  logic                  above_q, above_d;
  logic                  below_q, below_d;
  logic                  equal_q, equal_d;

  // The latched operands are shifted left as chunks match, so the chunk at
  // index idx_q always sits in the top CHUNK_WIDTH bits.
  logic [CHUNK_WIDTH-1:0] a_top, b_top;
  assign a_top = a_q[WORD_WIDTH-1 -: CHUNK_WIDTH];
  assign b_top = b_q[WORD_WIDTH-1 -: CHUNK_WIDTH];

  // Next-state logic: accept, chunk-by-chunk compare with early exit, done.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    above_d = above_q;
    below_d = below_q;
    equal_d = equal_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          idx_d   = IdxMax;
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (a_top != b_top) begin
          above_d = (a_top > b_top);
          below_d = (a_top < b_top);
          equal_d = 1'b0;
          state_d = StDone;
        end else if (idx_q == '0) begin
          above_d = 1'b0;
          below_d = 1'b0;
          equal_d = 1'b1;
          state_d = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
          a_d   = a_q << CHUNK_WIDTH;
          b_d   = b_q << CHUNK_WIDTH;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= IdxMax;
      a_q     <= '0;
      b_q     <= '0;
      above_q <= 1'b0;
      below_q <= 1'b0;
      equal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      above_q <= above_d;
      below_q <= below_d;
      equal_q <= equal_d;
    end
  end

  // Outputs decoded from state; result flags held until the next result.
  always_comb begin
    ready_o = (state_q == StIdle);
    valid_o = (state_q == StDone);
    above_o = above_q;
    below_o = below_q;
    equal_o = equal_q;
  end

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator (8-bit words, 2-bit chunks): directed scenarios
// plus a randomized sweep against an arithmetic reference model.
module tb_serial_comparator;

  localparam int W = 8;
  localparam int C = 2;
  localparam int N = W / C;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         valid_o;
  logic         above_o;
  logic         below_o;
  logic         equal_o;

  int n_checks = 0;
  int n_errors = 0;

  serial_comparator #(
    .WORD_WIDTH (W),
    .CHUNK_WIDTH(C)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(start_i),
    .ready_o(ready_o),
    .a_i    (a_i),
    .b_i    (b_i),
    .valid_o(valid_o),
    .above_o(above_o),
    .below_o(below_o),
    .equal_o(equal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Chunks examined: position (from MSB, 1-based) of first differing chunk, or N.
  function automatic int model_latency(input int a, input int b);
    int mask = (1 << C) - 1;
    for (int i = 0; i < N; i++) begin
      int sh = W - C * (i + 1);
      if (((a >> sh) & mask) != ((b >> sh) & mask)) return i + 1;
    end
    return N;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Launch one comparison and check latency, flags, pulse width and hold.
  // With poke set, a_i is scrambled and start_i held high while busy.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke);
    int exp_lat = model_latency(int'(a), int'(b));
    int a_v = int'(a);
    int b_v = int'(b);
    logic ea = (a_v > b_v);
    logic eb = (a_v < b_v);
    logic ee = (a_v == b_v);
    int cnt = 0;
    check({tag, ".ready_pre"}, ready_o, 1);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    tick();
    if (poke) begin
      a_i = '1;
      b_i = '0;
    end else begin
      start_i = 1'b0;
    end
    do begin
      check({tag, ".busy_ready"}, ready_o, 0);
      tick();
      cnt++;
    end while (!valid_o && cnt < 20);
    start_i = 1'b0;
    check({tag, ".latency"}, cnt, exp_lat);
    check({tag, ".valid"}, valid_o, 1);
    check({tag, ".ready_done"}, ready_o, 0);
    check({tag, ".flags"}, {above_o, below_o, equal_o}, {ea, eb, ee});
    tick();
    check({tag, ".valid_pulse"}, valid_o, 0);
    check({tag, ".ready_post"}, ready_o, 1);
    check({tag, ".flags_hold"}, {above_o, below_o, equal_o}, {ea, eb, ee});
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_ni  = 1'b0;
    start_i = 1'b1;  // must be ignored during reset
    a_i     = 8'h12;
    b_i     = 8'h34;
    tick();
    tick();
    start_i = 1'b0;
    check("rst.ready", ready_o, 1);
    check("rst.valid", valid_o, 0);
    check("rst.flags", {above_o, below_o, equal_o}, 3'b000);
    rst_ni = 1'b1;
    tick();
    check("rel.ready", ready_o, 1);
    check("rel.valid", valid_o, 0);
    check("rel.flags", {above_o, below_o, equal_o}, 3'b000);

    run_op("c0_40", 8'hC0, 8'h40, 1'b0);
    run_op("05_06", 8'h05, 8'h06, 1'b0);
    run_op("5a_5a", 8'h5A, 8'h5A, 1'b0);
    run_op("00_00", 8'h00, 8'h00, 1'b0);
    run_op("ff_ff", 8'hFF, 8'hFF, 1'b0);
    run_op("poke", 8'h10, 8'h20, 1'b1);
    tick();
    check("poke.no_second_valid", valid_o, 0);
    check("poke.idle", ready_o, 1);

    // Abort after the 2nd post-accept edge of a 4-chunk compare.
    a_i = 8'h01;
    b_i = 8'h02;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    check("abort.busy", ready_o, 0);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("abort.ready", ready_o, 1);
    check("abort.valid", valid_o, 0);
    check("abort.flags", {above_o, below_o, equal_o}, 3'b000);
    for (int i = 0; i < 4; i++) begin
      check("abort.no_valid", valid_o, 0);
      tick();
    end
    run_op("80_7f", 8'h80, 8'h7F, 1'b0);

    // Random sweep; half the pairs share a random-length MSB prefix.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        int keep = $urandom_range(0, N) * C;
        logic [W-1:0] m = 8'((1 << (W - keep)) - 1);
        rb = (ra & ~m) | (8'($urandom) & m);
      end else begin
        rb = 8'($urandom);
      end
      run_op("rand", ra, rb, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter WORD_WIDTH, default 16: operand width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK_WIDTH, default 4: bits compared per cycle; SHALL divide WORD_WIDTH exactly, with N = WORD_WIDTH / CHUNK_WIDTH.
REQ-003 clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 rst_ni, input, 1: reset, synchronous and active-low.
REQ-005 start_i, input, 1: request to compare a_i and b_i.
REQ-006 ready_o, output, 1: block idle and able to accept start_i.
REQ-007 a_i, input, WORD_WIDTH: unsigned operand A.
REQ-008 b_i, input, WORD_WIDTH: unsigned operand B.
REQ-009 valid_o, output, 1: result valid, one-cycle pulse.
REQ-010 above_o, output, 1: A > B.
REQ-011 below_o, output, 1: A < B.
REQ-012 equal_o, output, 1: A == B.

Function
REQ-013 The block SHALL have the states IDLE, COMPARE and DONE.
REQ-014 ready_o SHALL be 1 only in IDLE.
REQ-015 Accept: on an edge with state IDLE and start_i=1, the block SHALL latch a_i and b_i, set chunk index idx=N-1 and go to COMPARE.
REQ-016 start_i SHALL be ignored in COMPARE and DONE, with no queuing.
REQ-017 a_i and b_i changes after accept SHALL NOT affect the result.
REQ-018 In COMPARE, each edge SHALL compare latched chunk idx, bits [idx*CHUNK_WIDTH +: CHUNK_WIDTH], unsigned, MSB chunk first.
REQ-019 If the chunks differ, the block SHALL register above/below from that chunk, register equal=0 and go to DONE (early exit).
REQ-020 If the chunks are equal and idx=0, the block SHALL register above=0, below=0, equal=1 and go to DONE.
REQ-021 If the chunks are equal and idx>0, the block SHALL decrement idx and stay in COMPARE.
REQ-022 In DONE, valid_o SHALL be 1 for exactly one cycle, and the next edge SHALL return the block to IDLE unconditionally.
REQ-023 Latency: valid_o SHALL be high in the cycle following the k-th edge after the accept edge, where k (1..N) is the number of chunks examined; the next accept is possible k+2 edges after the previous one.
REQ-024 above_o, below_o and equal_o SHALL hold their last result through IDLE until the next result is registered, and SHALL be one-hot whenever a result exists.
REQ-025 For CHUNK_WIDTH = WORD_WIDTH (N=1), every comparison SHALL take exactly k=1.

Reset
REQ-026 rst_ni=0 at a clock edge SHALL force state IDLE, idx=N-1, valid_o=0, above_o=0, below_o=0, equal_o=0; ready_o SHALL be 1 after that edge.
REQ-027 Reset during COMPARE or DONE SHALL abort the operation with no valid_o pulse; the block SHALL accept start_i on the first edge with rst_ni=1.
REQ-028 start_i asserted while rst_ni=0 SHALL be ignored.

Verification (WORD_WIDTH=8, CHUNK_WIDTH=2, N=4)
REQ-029 Scenario: reset, then release -> ready_o=1, valid_o=0, above_o=below_o=equal_o=0.
REQ-030 Scenario: A=0xC0, B=0x40, start pulse -> valid_o one cycle after the 1st post-accept edge; above_o=1, below_o=0, equal_o=0.
REQ-031 Scenario: A=0x05, B=0x06 -> valid_o after the 4th post-accept edge; below_o=1, above_o=0.
REQ-032 Scenario: A=B=0x5A -> valid_o after the 4th edge; equal_o=1, others 0. Also A=B=0x00 and A=B=0xFF give the same response.
REQ-033 Scenario: accept A=0x10, B=0x20, then change a_i to 0xFF and pulse start_i during COMPARE -> result below_o=1 after 2 edges; only one valid_o pulse; ready_o=0 until IDLE.
REQ-034 Scenario: reset after the 2nd edge of A=0x01, B=0x02 -> no valid_o; outputs 0. A new start with A=0x80, B=0x7F -> above_o=1 after 1 edge.
REQ-035 Randomized sweep of 1000 operand pairs: results SHALL match A>B, A<B and A==B.
REQ-036 Randomized sweep: latency SHALL equal the index of the first differing chunk counted from the MSB, or N if the operands are equal.
